rf_writeback_arbiter: RTL and testbench
=======================================

# rf_writeback_arbiter

Write-side driver for the CPU register file write port (`reg_write_en` / `reg_write_dest` / `reg_write_data`). It merges two result producers, the single-cycle ALU path and the variable-latency load path, into one registered write per cycle. Load results are buffered so that ALU results keep priority without losing load data. The block also exports a pending-write mask that issue logic uses for RAW hazard stalls.

## Interface
- `XLEN`, 32: data width.
- `LQ_DEPTH`, 4: load-result queue entries (power of two, ≥2).
- `STARVE_LIMIT`, 8: consecutive cycles a non-empty queue may be blocked by ALU before the ALU is held off.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `alu_valid`  in  1  ALU result present.
- `alu_ready`  out  1  ALU result accepted this cycle.
- `alu_dest`  in  5  destination register.
- `alu_data`  in  XLEN  result.
- `ld_valid`  in  1  load result present.
- `ld_ready`  out  1  load result accepted this cycle.
- `ld_dest`  in  5  destination register.
- `ld_data`  in  XLEN  load data.
- `reg_write_en`  out  1  register file write strobe (registered).
- `reg_write_dest`  out  5  write address (registered).
- `reg_write_data`  out  XLEN  write data (registered).
- `busy_mask`  out  32  bit d set while a load write to xd is queued or in the output register.

## Operation
- One clock; reset is asynchronous and active-low.
- Transfers occur on `valid & ready` at a rising edge. `ld_ready = (count != LQ_DEPTH)`. There is no same-cycle dequeue credit.
- `alu_ready = !hold`. `hold` is asserted for exactly one cycle when the starve counter reaches `STARVE_LIMIT`.
- Output-register source select, in priority order:
  - ALU transfer, if `alu_valid & alu_ready`;
  - otherwise the queue head, if `count != 0`;
  - otherwise nothing (`reg_write_en` = 0 next cycle).
- Starve counter:
  - increments each cycle the queue is non-empty and an ALU transfer wins;
  - clears when the queue pops or becomes empty;
  - saturates at `STARVE_LIMIT`.
  - While `hold` is set, the queue head is popped. The counter clears and `hold` drops the next cycle.
- Destination x0:
  - accepted on either channel under normal handshake;
  - never enqueued and never produces `reg_write_en` = 1;
  - when x0 and a real write would both be eligible, the real write is not delayed by x0.
- The queue is FIFO; load order is preserved. ALU and load writes are not reordered against each other beyond the priority above. Issue logic guarantees no same-destination ALU/load race and uses `busy_mask` to enforce this.
- `busy_mask` is the combinational OR of decoded destinations of valid queue entries, plus the output register if it holds a load write.

## Timing
- Reset values: `reg_write_en` 0, `reg_write_dest` 0, `reg_write_data` 0, `busy_mask` 0, `count` 0, starve counter 0, `hold` 0.
- Outputs on reset: `alu_ready` 1, `ld_ready` 1.
- Reset mid-operation discards all queued writes immediately (async).
- ALU latency: accepted at edge N → write strobe valid in cycle N+1.
- Load latency:
  - accepted at edge N, queue otherwise idle, no ALU transfer → write in cycle N+2;
  - each ALU win adds one cycle.
- Simultaneous enqueue and dequeue when full: not accepted (`ld_ready` = 0). When neither full nor empty, both occur and `count` is unchanged.
- Queue pointers wrap modulo `LQ_DEPTH`.

## Configuration
- `RF_WB_BYPASS_EN` defined:
  - a load accepted while the queue is empty and no ALU transfer occurs that cycle skips the queue and is written in cycle N+1;
  - `busy_mask` covers it through the output register only.
- Undefined: every load passes through the queue (N+2 minimum).

## Structure
- Package `rf_wb_pkg` holds:
  - `XLEN`, `REG_ADDR_W` = 5, `NUM_REGS` = 32;
  - a write-entry struct {dest, data};
  - a decode-to-onehot function for `busy_mask`.
- Sub-module `rf_wb_fifo` holds:
  - parameterised queue with count, push/pop, head outputs;
  - a per-entry valid/dest vector exposed for the mask.
- The top level holds the arbiter, starve counter and output register.

## Test plan
- ALU only: `alu_valid`=1, dest 5, data 0x12345678 at edge N → cycle N+1 `reg_write_en`=1, dest 5, data 0x12345678; next cycle `reg_write_en`=0.
- Load only, idle ALU: dest 7, data 0xDEADBEEF at N → write in N+2. With `RF_WB_BYPASS_EN`, write in N+1. `busy_mask[7]`=1 until the cycle after the write.
- Starvation:
  - stimulus: ALU valid every cycle; 5 loads offered to x10..x14.
  - required: 4 accepted, then `ld_ready`=0; after 8 ALU wins `alu_ready`=0 for one cycle and x10 is written; order x10..x13 preserved.
- x0 filter: ALU dest 0 data 0xFFFFFFFF and load dest 0 → both handshakes complete, `reg_write_en` never 1, `busy_mask`=0.
- Reset mid-operation:
  - stimulus: 3 loads queued; `rst_n` dropped between edges.
  - required: outputs 0, `busy_mask` 0 immediately; after release no stale write appears.
- Wrap-around: 12 loads streamed with the ALU idle → writes appear in order with data intact across 3 pointer wraps.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
package rf_wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // x0 is hardwired, so it never marks a register busy.
  function automatic logic [NUM_REGS-1:0] dest_onehot(input logic [REG_ADDR_W-1:0] dest);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    if (dest != '0) oh[dest] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Load-result queue: power-of-two FIFO with per-entry valid/dest taps for the busy mask.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_push,
  input  wb_entry_t                           i_push_entry,
  input  logic                                i_pop,
  output wb_entry_t                           o_head,
  output logic [CNT_W-1:0]                    o_count,
  output logic                                o_full,
  output logic                                o_empty,
  output logic [DEPTH-1:0]                    o_ent_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    o_ent_dest
);

  wb_entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [DEPTH-1:0]   r_valid;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_do_pop) begin
        r_rd_ptr          <= r_rd_ptr + 1'b1;
        r_valid[r_rd_ptr] <= 1'b0;
      end
      if (w_do_push) begin
        r_wr_ptr          <= r_wr_ptr + 1'b1;
        r_valid[r_wr_ptr] <= 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_entry;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) o_ent_dest[i] = r_mem[i].dest;
  end

  assign o_head      = r_mem[r_rd_ptr];
  assign o_count     = r_count;
  assign o_ent_valid = r_valid;

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges ALU and load results into one registered register-file write per cycle.
// Optional feature: define RF_WB_BYPASS_EN to let a load skip an empty queue.
module rf_writeback_arbiter
  import rf_wb_pkg::*;
#(
  parameter int LQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_alu_valid,
  output logic                  o_alu_ready,
  input  logic [REG_ADDR_W-1:0] i_alu_dest,
  input  logic [XLEN-1:0]       i_alu_data,
  input  logic                  i_ld_valid,
  output logic                  o_ld_ready,
  input  logic [REG_ADDR_W-1:0] i_ld_dest,
  input  logic [XLEN-1:0]       i_ld_data,
  output logic                  o_reg_write_en,
  output logic [REG_ADDR_W-1:0] o_reg_write_dest,
  output logic [XLEN-1:0]       o_reg_write_data,
  output logic [NUM_REGS-1:0]   o_busy_mask
);

  localparam int CNT_W = $clog2(LQ_DEPTH + 1);
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [ST_W-1:0] ST_MAX = ST_W'(STARVE_LIMIT);

  logic                           r_wr_en;
  logic                           r_wr_is_ld;
  logic [REG_ADDR_W-1:0]          r_wr_dest;
  logic [XLEN-1:0]                r_wr_data;
  logic [ST_W-1:0]                r_starve;
  logic                           r_hold;

  wb_entry_t                      w_ld_entry;
  wb_entry_t                      w_head;
  logic [CNT_W-1:0]               w_count;
  logic                           w_full;
  logic                           w_empty;
  logic [LQ_DEPTH-1:0]            w_ent_valid;
  logic [LQ_DEPTH-1:0][REG_ADDR_W-1:0] w_ent_dest;

  logic                           w_alu_xfer;
  logic                           w_alu_win;
  logic                           w_ld_xfer;
  logic                           w_ld_real;
  logic                           w_bypass;
  logic                           w_push;
  logic                           w_pop;
  logic                           w_empty_nxt;
  logic [ST_W-1:0]                w_starve_nxt;
  logic [NUM_REGS-1:0]            w_busy;

  assign o_alu_ready = ~r_hold;
  assign o_ld_ready  = ~w_full;

  // x0 transfers complete the handshake but never claim the output register.
  assign w_alu_xfer = i_alu_valid & ~r_hold;
  assign w_alu_win  = w_alu_xfer & (i_alu_dest != '0);
  assign w_ld_xfer  = i_ld_valid & ~w_full;
  assign w_ld_real  = w_ld_xfer & (i_ld_dest != '0);

`ifdef RF_WB_BYPASS_EN
  assign w_bypass = w_ld_real & w_empty & ~w_alu_win;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_ld_real & ~w_bypass;
  assign w_pop  = ~w_alu_win & ~w_empty;

  always_comb begin
    w_ld_entry      = '0;
    w_ld_entry.dest = i_ld_dest;
    w_ld_entry.data = i_ld_data;
  end

  rf_wb_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_fifo (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_push       (w_push),
    .i_push_entry (w_ld_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_count      (w_count),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_ent_valid  (w_ent_valid),
    .o_ent_dest   (w_ent_dest)
  );

  assign w_empty_nxt = (w_empty & ~w_push) |
                       ((w_count == CNT_W'(1)) & w_pop & ~w_push);

  // Starve counter only advances while a queued load is being passed over.
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_pop || w_empty_nxt) begin
      w_starve_nxt = '0;
    end else if (w_alu_win && !w_empty && (r_starve != ST_MAX)) begin
      w_starve_nxt = r_starve + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve <= '0;
      r_hold   <= 1'b0;
    end else begin
      r_starve <= w_starve_nxt;
      r_hold   <= (w_starve_nxt == ST_MAX);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_en    <= 1'b0;
      r_wr_is_ld <= 1'b0;
      r_wr_dest  <= '0;
      r_wr_data  <= '0;
    end else if (w_alu_win) begin
      r_wr_en    <= 1'b1;
      r_wr_is_ld <= 1'b0;
      r_wr_dest  <= i_alu_dest;
      r_wr_data  <= i_alu_data;
    end else if (w_pop) begin
      r_wr_en    <= 1'b1;
      r_wr_is_ld <= 1'b1;
      r_wr_dest  <= w_head.dest;
      r_wr_data  <= w_head.data;
    end else if (w_bypass) begin
      r_wr_en    <= 1'b1;
      r_wr_is_ld <= 1'b1;
      r_wr_dest  <= i_ld_dest;
      r_wr_data  <= i_ld_data;
    end else begin
      r_wr_en    <= 1'b0;
      r_wr_is_ld <= 1'b0;
    end
  end

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (w_ent_valid[i]) w_busy = w_busy | dest_onehot(w_ent_dest[i]);
    end
    if (r_wr_en && r_wr_is_ld) w_busy = w_busy | dest_onehot(r_wr_dest);
  end

  assign o_reg_write_en   = r_wr_en;
  assign o_reg_write_dest = r_wr_dest;
  assign o_reg_write_data = r_wr_data;
  assign o_busy_mask      = w_busy;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed and random checks of rf_writeback_arbiter against a queue-based cycle model.
module tb_rf_writeback_arbiter;

  localparam int LQ_DEPTH     = 4;
  localparam int STARVE_LIMIT = 8;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_dest = '0;
  logic [31:0] alu_data = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_dest = '0;
  logic [31:0] ld_data = '0;
  logic        wr_en;
  logic [4:0]  wr_dest;
  logic [31:0] wr_data;
  logic [31:0] busy_mask;

  int n_checks = 0;
  int n_errors = 0;

  ent_t        m_q[$];
  int          m_starve;
  bit          m_hold;
  bit          m_out_en;
  bit          m_out_ld;
  logic [4:0]  m_out_dest;
  logic [31:0] m_out_data;
  ent_t        w_log[$];

  rf_writeback_arbiter #(
    .LQ_DEPTH     (LQ_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_alu_valid      (alu_valid),
    .o_alu_ready      (alu_ready),
    .i_alu_dest       (alu_dest),
    .i_alu_data       (alu_data),
    .i_ld_valid       (ld_valid),
    .o_ld_ready       (ld_ready),
    .i_ld_dest        (ld_dest),
    .i_ld_data        (ld_data),
    .o_reg_write_en   (wr_en),
    .o_reg_write_dest (wr_dest),
    .o_reg_write_data (wr_data),
    .o_busy_mask      (busy_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_starve   = 0;
    m_hold     = 1'b0;
    m_out_en   = 1'b0;
    m_out_ld   = 1'b0;
    m_out_dest = '0;
    m_out_data = '0;
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    foreach (m_q[i]) b[m_q[i].dest] = 1'b1;
    if (m_out_en && m_out_ld) b[m_out_dest] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  // One rising edge of the behavioural model, using the inputs currently driven.
  task automatic model_edge();
    bit   alu_acc, ld_acc, empty0, bypassed;
    ent_t head;
    empty0   = (m_q.size() == 0);
    alu_acc  = alu_valid && !m_hold;
    ld_acc   = ld_valid && (m_q.size() < LQ_DEPTH);
    bypassed = 1'b0;
    if (alu_acc && alu_dest != 0) begin
      m_out_en = 1'b1; m_out_ld = 1'b0; m_out_dest = alu_dest; m_out_data = alu_data;
      if (!empty0 && m_starve < STARVE_LIMIT) m_starve++;
    end else if (!empty0) begin
      head = m_q.pop_front();
      m_out_en = 1'b1; m_out_ld = 1'b1; m_out_dest = head.dest; m_out_data = head.data;
      m_starve = 0;
    end else begin
      m_out_en = 1'b0; m_out_ld = 1'b0;
`ifdef RF_WB_BYPASS_EN
      if (ld_acc && ld_dest != 0) begin
        m_out_en = 1'b1; m_out_ld = 1'b1; m_out_dest = ld_dest; m_out_data = ld_data;
        bypassed = 1'b1;
      end
`endif
    end
    if (ld_acc && ld_dest != 0 && !bypassed) m_q.push_back('{dest: ld_dest, data: ld_data});
    if (m_q.size() == 0) m_starve = 0;
    m_hold = (m_starve == STARVE_LIMIT);
  endtask

  task automatic step();
    chk("alu_ready", alu_ready, !m_hold);
    chk("ld_ready", ld_ready, m_q.size() < LQ_DEPTH);
    @(posedge clk);
    model_edge();
    #1;
    chk("wr_en", wr_en, m_out_en);
    if (m_out_en) begin
      chk("wr_dest", wr_dest, m_out_dest);
      chk("wr_data", wr_data, m_out_data);
    end
    chk("busy_mask", busy_mask, model_busy());
    if (wr_en === 1'b1) w_log.push_back('{dest: wr_dest, data: wr_data});
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
  endtask

  initial begin
    int   full_at, hold_at, li, nacc;
    logic lr;
    ent_t exp_ld[$];
    ent_t got[$];

    model_reset();
    #12;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_dest", wr_dest, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_ld_ready", ld_ready, 1);
    rst_n = 1'b1;
    step();

    // ALU only
    alu_valid = 1'b1; alu_dest = 5; alu_data = 32'h1234_5678;
    step();
    idle_inputs();
    chk("alu_wr_en", wr_en, 1);
    chk("alu_wr_dest", wr_dest, 5);
    chk("alu_wr_data", wr_data, 32'h1234_5678);
    step();
    chk("alu_wr_en_after", wr_en, 0);

    // Load only, ALU idle
    ld_valid = 1'b1; ld_dest = 7; ld_data = 32'hDEAD_BEEF;
    step();
    idle_inputs();
`ifndef RF_WB_BYPASS_EN
    chk("ld_n1_wr_en", wr_en, 0);
    chk("ld_n1_busy7", busy_mask[7], 1);
    step();
`endif
    chk("ld_wr_en", wr_en, 1);
    chk("ld_wr_dest", wr_dest, 7);
    chk("ld_wr_data", wr_data, 32'hDEAD_BEEF);
    chk("ld_wr_busy7", busy_mask[7], 1);
    step();
    chk("ld_after_busy7", busy_mask[7], 0);
    chk("ld_after_wr_en", wr_en, 0);

    // x0 filter
    alu_valid = 1'b1; alu_dest = 0; alu_data = 32'hFFFF_FFFF;
    ld_valid  = 1'b1; ld_dest  = 0; ld_data  = $urandom;
    chk("x0_alu_ready", alu_ready, 1);
    chk("x0_ld_ready", ld_ready, 1);
    step();
    idle_inputs();
    chk("x0_wr_en", wr_en, 0);
    chk("x0_busy", busy_mask, 0);
    step();
    chk("x0_wr_en2", wr_en, 0);
    chk("x0_busy2", busy_mask, 0);
    ld_valid = 1'b1; ld_dest = 3; ld_data = 32'hA5A5_A5A5;
    step();
    ld_valid = 1'b0;
    alu_valid = 1'b1; alu_dest = 0; alu_data = 32'h0BAD_0BAD;
    step();
    idle_inputs();
    chk("x0_nodelay_en", wr_en, 1);
    chk("x0_nodelay_dest", wr_dest, 3);
    chk("x0_nodelay_data", wr_data, 32'hA5A5_A5A5);
    step();

    // Starvation: ALU valid every cycle, loads to x10..x14
    w_log.delete();
    full_at = -1; hold_at = -1; li = 0; nacc = 0;
    alu_valid = 1'b1; alu_dest = 20;
    for (int k = 1; k <= 40; k++) begin
      alu_data = $urandom;
      if (li < 5) begin
        ld_valid = 1'b1; ld_dest = 5'(10 + li); ld_data = 32'hA000_0000 + li;
      end else begin
        ld_valid = 1'b0;
      end
      lr = ld_ready;
      if (li < 5 && lr === 1'b0 && full_at < 0) full_at = nacc;
      step();
      if (ld_valid && lr === 1'b1) begin li++; nacc++; end
      if (hold_at >= 0 && k == hold_at + 1) begin
        chk("starve_pop_en", wr_en, 1);
        chk("starve_pop_dest", wr_dest, 10);
        chk("starve_hold_len", alu_ready, 1);
      end
      if (alu_ready === 1'b0 && hold_at < 0) hold_at = k;
    end
    idle_inputs();
    for (int k = 0; k < 10; k++) step();
    chk("starve_accepted_before_full", full_at, 4);
    chk("starve_hold_step", hold_at, STARVE_LIMIT + 1);
    got.delete();
    foreach (w_log[i]) if (w_log[i].dest >= 10 && w_log[i].dest <= 14) got.push_back(w_log[i]);
    chk("starve_ld_count", got.size(), 5);
    foreach (got[i]) begin
      chk("starve_order_dest", got[i].dest, 10 + i);
      chk("starve_order_data", got[i].data, 32'hA000_0000 + i);
    end

    // Reset mid-operation with three loads queued
    alu_valid = 1'b1; alu_dest = 21;
    for (int k = 0; k < 3; k++) begin
      alu_data = $urandom;
      ld_valid = 1'b1; ld_dest = 5'(1 + k); ld_data = $urandom;
      step();
    end
    idle_inputs();
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_wr_dest", wr_dest, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_busy", busy_mask, 0);
    chk("mid_rst_alu_ready", alu_ready, 1);
    chk("mid_rst_ld_ready", ld_ready, 1);
    model_reset();
    #10;
    rst_n = 1'b1;
    #6;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("post_rst_no_write", wr_en, 0);
    end

    // Wrap-around: 12 loads streamed, ALU idle
    w_log.delete();
    exp_ld.delete();
    li = 0;
    for (int k = 0; k < 40 && li < 12; k++) begin
      ld_valid = 1'b1; ld_dest = 5'(1 + li); ld_data = $urandom;
      lr = ld_ready;
      step();
      if (lr === 1'b1) begin
        exp_ld.push_back('{dest: ld_dest, data: ld_data});
        li++;
      end
    end
    idle_inputs();
    for (int k = 0; k < 6; k++) step();
    chk("wrap_count", w_log.size(), 12);
    foreach (w_log[i]) begin
      if (i < exp_ld.size()) begin
        chk("wrap_dest", w_log[i].dest, exp_ld[i].dest);
        chk("wrap_data", w_log[i].data, exp_ld[i].data);
      end
    end

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      alu_valid = ($urandom_range(0, 99) < 60);
      alu_dest  = 5'($urandom_range(0, 31));
      alu_data  = $urandom;
      ld_valid  = ($urandom_range(0, 99) < 50);
      ld_dest   = 5'($urandom_range(0, 31));
      ld_data   = $urandom;
      step();
    end
    idle_inputs();
    for (int k = 0; k < 12; k++) step();
    chk("final_drained_busy", busy_mask, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
